// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared encodings and defaults for the immediate generator
package imm_pkg;

    localparam int IMM_XLEN_DEFAULT = 32;
    localparam int IMM_SRC_W        = 3;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b100;
    localparam logic [IMM_SRC_W-1:0] IMM_Z = 3'b101;

    // Widest legal entry; a pipeline instance narrows it to its own XLEN/TAG_W.
    typedef struct packed {
        logic [63:0] imm;
        logic [15:0] tag;
        logic        err;
    } imm_entry_max_t;

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate extraction and extension
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = IMM_XLEN_DEFAULT
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    logic [31:0] imm32;
    logic        sext;
    logic        sign;
    logic [6:0]  unused_opcode;

    assign sign          = instr[31];
    assign unused_opcode = instr[6:0];

    always_comb begin
        imm32 = '0;
        sext  = 1'b1;
        err   = 1'b0;
        case (imm_src)
            IMM_I: imm32 = {{20{sign}}, instr[31:20]};
            IMM_S: imm32 = {{20{sign}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z: begin
                imm32 = {27'b0, instr[19:15]};
                sext  = 1'b0;
            end
            default: begin
                imm32 = '0;
                err   = 1'b1;
            end
        endcase
    end

    // 32-bit result already carries instr[31] in its MSB for every signed format.
    assign imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = IMM_XLEN_DEFAULT,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [IMM_SRC_W-1:0] in_imm_src,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t out_q, out_d, skid_q, skid_d, new_entry;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   accept;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (new_entry.imm),
        .err     (new_entry.err)
    );
    assign new_entry.tag = in_tag;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // SKID holds the older entry, and accept is blocked whenever it is full.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_q.imm;
    assign out_tag   = out_q.tag;
    assign out_err   = out_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic test_reset();
        checks++;
        if ({out_valid32, out_imm32, out_tag32, out_err32, in_ready32} !== {1'b0, 32'h0, 8'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset32 valid=%b imm=%h tag=%h err=%b rdy=%b, need 0 0 0 0 1",
                     out_valid32, out_imm32, out_tag32, out_err32, in_ready32);
        end
        checks++;
        if ({out_valid64, out_imm64, out_tag64, out_err64, in_ready64} !== {1'b0, 64'h0, 8'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset64 valid=%b imm=%h tag=%h err=%b rdy=%b, need 0 0 0 0 1",
                     out_valid64, out_imm64, out_tag64, out_err64, in_ready64);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [5];
        logic [2:0]  src [5];
        logic [31:0] exp [5];
        ins = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
        src = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        exp = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_instr   = ins[i];
            in_imm_src = src[i];
            in_tag     = 8'(8'h10 + i);
            checks++;
            if (in_ready32 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got %b need 1", i, in_ready32);
            end
            @(negedge clk);
            checks++;
            if ({out_valid32, out_imm32, out_tag32, out_err32} !== {1'b1, exp[i], 8'(8'h10 + i), 1'b0}) begin
                errors++;
                $display("FAIL b2b[%0d] valid=%b imm=%h tag=%h err=%b, need 1 %h %h 0",
                         i, out_valid32, out_imm32, out_tag32, out_err32, exp[i], 8'(8'h10 + i));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain valid=%b need 0", out_valid32);
        end
    endtask

    task automatic test_xlen64();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 32'h800002B7;
        in_imm_src = 3'b011;
        in_tag     = 8'h21;
        @(negedge clk);
        checks++;
        if ({out_valid64, out_imm64, out_tag64} !== {1'b1, 64'hFFFFFFFF80000000, 8'h21}) begin
            errors++;
            $display("FAIL x64_u valid=%b imm=%h tag=%h, need 1 ffffffff80000000 21",
                     out_valid64, out_imm64, out_tag64);
        end
        checks++;
        if (out_imm32 !== 32'h80000000) begin
            errors++;
            $display("FAIL x32_u imm=%h need 80000000", out_imm32);
        end
        in_instr   = 32'h3400F073;
        in_imm_src = 3'b101;
        in_tag     = 8'h22;
        @(negedge clk);
        checks++;
        if ({out_valid64, out_imm64, out_tag64, out_err64} !== {1'b1, 64'h1, 8'h22, 1'b0}) begin
            errors++;
            $display("FAIL x64_z valid=%b imm=%h tag=%h err=%b, need 1 0000000000000001 22 0",
                     out_valid64, out_imm64, out_tag64, out_err64);
        end
        // Z on a word with instr[31]=1 must stay zero-extended.
        in_instr = 32'hFFFFFFFF;
        in_tag   = 8'h23;
        @(negedge clk);
        checks++;
        if (out_imm64 !== 64'h1F) begin
            errors++;
            $display("FAIL x64_z_neg imm=%h need 000000000000001f", out_imm64);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_instr   = 32'h00100093;
        in_imm_src = 3'b000;
        in_tag     = 8'd1;
        @(negedge clk);
        checks++;
        if ({out_valid32, out_tag32, out_imm32, in_ready32} !== {1'b1, 8'd1, 32'd1, 1'b1}) begin
            errors++;
            $display("FAIL bp_first valid=%b tag=%0d imm=%h rdy=%b, need 1 1 00000001 1",
                     out_valid32, out_tag32, out_imm32, in_ready32);
        end
        in_instr = 32'h00200093;
        in_tag   = 8'd2;
        @(negedge clk);
        checks++;
        if ({out_valid32, out_tag32, out_imm32, in_ready32} !== {1'b1, 8'd1, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL bp_skid valid=%b tag=%0d imm=%h rdy=%b, need 1 1 00000001 0",
                     out_valid32, out_tag32, out_imm32, in_ready32);
        end
        in_instr = 32'h00300093;
        in_tag   = 8'd3;
        @(negedge clk);
        checks++;
        if ({out_valid32, out_tag32, out_imm32, in_ready32} !== {1'b1, 8'd1, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold valid=%b tag=%0d imm=%h rdy=%b, need 1 1 00000001 0",
                     out_valid32, out_tag32, out_imm32, in_ready32);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid32, out_tag32, out_imm32, in_ready32} !== {1'b1, 8'd2, 32'd2, 1'b1}) begin
            errors++;
            $display("FAIL bp_out2 valid=%b tag=%0d imm=%h rdy=%b, need 1 2 00000002 1",
                     out_valid32, out_tag32, out_imm32, in_ready32);
        end
        @(negedge clk);
        checks++;
        if ({out_valid32, out_tag32, out_imm32} !== {1'b1, 8'd3, 32'd3}) begin
            errors++;
            $display("FAIL bp_out3 valid=%b tag=%0d imm=%h, need 1 3 00000003",
                     out_valid32, out_tag32, out_imm32);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_nodup valid=%b tag=%0d, need valid 0", out_valid32, out_tag32);
        end
    endtask

    task automatic test_illegal();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 32'hFFF00093;
        in_imm_src = 3'b111;
        in_tag     = 8'h40;
        @(negedge clk);
        checks++;
        if ({out_valid32, out_imm32, out_tag32, out_err32} !== {1'b1, 32'h0, 8'h40, 1'b1}) begin
            errors++;
            $display("FAIL illegal111 valid=%b imm=%h tag=%h err=%b, need 1 0 40 1",
                     out_valid32, out_imm32, out_tag32, out_err32);
        end
        in_imm_src = 3'b110;
        in_tag     = 8'h41;
        @(negedge clk);
        checks++;
        if ({out_imm64, out_err64} !== {64'h0, 1'b1}) begin
            errors++;
            $display("FAIL illegal110 imm=%h err=%b, need 0 1", out_imm64, out_err64);
        end
        in_imm_src = 3'b000;
        in_tag     = 8'h42;
        @(negedge clk);
        checks++;
        if ({out_imm32, out_tag32, out_err32} !== {32'hFFFFFFFF, 8'h42, 1'b0}) begin
            errors++;
            $display("FAIL illegal_next imm=%h tag=%h err=%b, need ffffffff 42 0",
                     out_imm32, out_tag32, out_err32);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_instr   = 32'h00500093;
        in_imm_src = 3'b000;
        in_tag     = 8'h51;
        @(negedge clk);
        in_tag = 8'h52;
        @(negedge clk);
        checks++;
        if ({out_valid32, in_ready32} !== 2'b10) begin
            errors++;
            $display("FAIL flush_fill valid=%b rdy=%b, need 1 0", out_valid32, in_ready32);
        end
        flush  = 1'b1;
        in_tag = 8'h53;
        @(negedge clk);
        checks++;
        if ({out_valid32, in_ready32} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full valid=%b rdy=%b, need 0 1", out_valid32, in_ready32);
        end
        // Flush again with in_ready high: the offered entry must still be dropped.
        in_tag = 8'h54;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL flush_capture valid=%b tag=%h, need valid 0", out_valid32, out_tag32);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid32, in_ready32} !== 2'b01) begin
            errors++;
            $display("FAIL flush_after valid=%b rdy=%b, need 0 1", out_valid32, in_ready32);
        end
    endtask

    task automatic test_async_reset();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_instr   = 32'h00700093;
        in_imm_src = 3'b000;
        in_tag     = 8'h71;
        @(negedge clk);
        in_tag = 8'h72;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst        = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 32'h12345037;
        in_imm_src = 3'b011;
        in_tag     = 8'h73;
        @(negedge clk);
        checks++;
        if ({out_valid32, out_imm32, out_tag32} !== {1'b1, 32'h12345000, 8'h73}) begin
            errors++;
            $display("FAIL rst_resume valid=%b imm=%h tag=%h, need 1 12345000 73",
                     out_valid32, out_imm32, out_tag32);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm_src = '0;
        in_tag     = '0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_back_to_back();
        test_xlen64();
        test_backpressure();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
